// File: rtl/kamikaze_pkg.sv
// Shared definitions for the kamikaze instruction-memory slice: boot sequencer
// states, the core start address and the byte-lane merge helper.
package kamikaze_pkg;

  typedef enum logic [1:0] {
    IMEM_CLEAR,
    IMEM_LOAD,
    IMEM_RUN
  } imem_state_t;

  localparam logic [31:0] CPU_START = 32'h0;

  // Replace the byte lanes of old_word selected by be with those of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_word;
    for (int unsigned k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = new_word[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/kamikaze_imem_ram.sv
// DEPTH_WORDS x 32 instruction array: one byte-enable write port and one
// registered read port that sees a same-cycle write to the same word.
module kamikaze_imem_ram
  import kamikaze_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wbe_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          rzero_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= merge_lanes(mem[waddr_i], wdata_i, wbe_i);
  end

  // Only the output register is reset; the array keeps whatever it held.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_o <= '0;
    end else if (rzero_i) begin
      rdata_o <= '0;
    end else if (we_i && (waddr_i == raddr_i)) begin
      rdata_o <= merge_lanes(mem[raddr_i], wdata_i, wbe_i);
    end else begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/kamikaze_imem.sv
// Instruction memory responder for kamikaze fetch with a 1-cycle read bus,
// a handshaked loader write port and the CLEAR -> LOAD -> RUN boot sequencer.
module kamikaze_imem
  import kamikaze_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR      = CPU_START,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_range_err_o,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i,
  input  logic [3:0]  ld_be_i,
  input  logic        ld_done_i,
  output logic        ld_err_o,
  output logic        cpu_run_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam imem_state_t RESET_STATE = CLEAR_ON_RESET ? IMEM_CLEAR : IMEM_LOAD;

  imem_state_t   state_q, state_d;
  logic [AW-1:0] clr_cnt_q;
  logic          done_pend_q;

  // 33-bit subtraction: the borrow flags addresses below BASE_ADDR, so nothing
  // wraps back into the array.
  logic [32:0]   rd_off, ld_off;
  logic          rd_in_range, ld_in_range;
  logic [AW-1:0] rd_idx, ld_idx;
  logic          unused_lsb;

  assign rd_off      = {1'b0, im_addr_i} - {1'b0, BASE_ADDR};
  assign ld_off      = {1'b0, ld_addr_i} - {1'b0, BASE_ADDR};
  assign rd_in_range = !rd_off[32] && (rd_off[31:AW+2] == '0);
  assign ld_in_range = !ld_off[32] && (ld_off[31:AW+2] == '0);
  assign rd_idx      = rd_off[AW+1:2];
  assign ld_idx      = ld_off[AW+1:2];
  assign unused_lsb  = ^{rd_off[1:0], ld_off[1:0]};

  logic          ld_fire;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;

  assign ld_fire = ld_valid_i && ld_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IMEM_CLEAR: if (&clr_cnt_q) state_d = IMEM_LOAD;
      IMEM_LOAD:  if (ld_done_i || done_pend_q) state_d = IMEM_RUN;
      IMEM_RUN:   state_d = IMEM_RUN;
      default:    state_d = RESET_STATE;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ld_idx;
    wr_data = ld_data_i;
    wr_be   = ld_be_i;
    if (state_q == IMEM_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_cnt_q;
      wr_data = '0;
      wr_be   = '1;
    end else begin
      wr_en = ld_fire && ld_in_range;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= RESET_STATE;
      clr_cnt_q      <= '0;
      done_pend_q    <= 1'b0;
      ld_ready_o     <= 1'b0;
      ld_err_o       <= 1'b0;
      cpu_run_o      <= 1'b0;
      im_range_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IMEM_CLEAR) begin
        clr_cnt_q <= clr_cnt_q + AW'(1);
        if (ld_done_i) done_pend_q <= 1'b1;
      end
      // Ready tracks the state being entered so it is high exactly in LOAD/RUN.
      ld_ready_o     <= (state_d != IMEM_CLEAR);
      cpu_run_o      <= (state_q == IMEM_RUN);
      im_range_err_o <= !rd_in_range;
      if (ld_fire && !ld_in_range) ld_err_o <= 1'b1;
    end
  end

  kamikaze_imem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_en),
    .waddr_i (wr_idx),
    .wdata_i (wr_data),
    .wbe_i   (wr_be),
    .raddr_i (rd_idx),
    .rzero_i ((state_q == IMEM_CLEAR) || !rd_in_range),
    .rdata_o (im_data_o)
  );

endmodule

// File: tb/tb_kamikaze_imem.sv
// Self-checking bench for kamikaze_imem: directed table, boot/reset sequences
// and randomized traffic against a word-array reference model.
module tb_kamikaze_imem;

  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int unsigned DEPTH2 = 8;
  localparam logic [31:0] BASE2  = 32'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] im_addr = '0, im_data;
  logic        im_rerr;
  logic        ld_valid = 1'b0, ld_ready, ld_done = 1'b0, ld_err, cpu_run;
  logic [31:0] ld_addr = '0, ld_data = '0;
  logic [3:0]  ld_be = '0;

  logic [31:0] im_addr2 = '0, im_data2, ld_addr2 = '0;
  logic        im_rerr2, ld_valid2 = 1'b0, ld_ready2, ld_err2, cpu_run2;

  int errors = 0;
  int checks = 0;

  logic [31:0] mm [DEPTH];
  logic        m_err;

  always #5 clk = ~clk;

  kamikaze_imem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .im_addr_i(im_addr), .im_data_o(im_data),
    .im_range_err_o(im_rerr), .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_be_i(ld_be), .ld_done_i(ld_done),
    .ld_err_o(ld_err), .cpu_run_o(cpu_run)
  );

  kamikaze_imem #(.DEPTH_WORDS(DEPTH2), .BASE_ADDR(BASE2), .CLEAR_ON_RESET(1'b0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .im_addr_i(im_addr2), .im_data_o(im_data2),
    .im_range_err_o(im_rerr2), .ld_valid_i(ld_valid2), .ld_ready_o(ld_ready2),
    .ld_addr_i(ld_addr2), .ld_data_i(32'hFFFF_FFFF), .ld_be_i(4'hF), .ld_done_i(1'b0),
    .ld_err_o(ld_err2), .cpu_run_o(cpu_run2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit m_in(input logic [31:0] a, input logic [31:0] base, input int unsigned depth);
    longint unsigned la, lb;
    la = a;
    lb = base;
    return (la >= lb) && ((la - lb) / 4 < depth);
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One LOAD/RUN cycle on the main DUT; the model applies the write before the
  // read so same-word collisions come out write-first.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic done, input logic [31:0] ia,
                     output logic [31:0] ed, output logic er);
    int unsigned w;
    ld_valid = v; ld_addr = a; ld_data = d; ld_be = be; ld_done = done; im_addr = ia;
    if (v) begin
      if (m_in(a, BASE, DEPTH)) begin
        w = (a - BASE) / 4;
        mm[w] = m_merge(mm[w], d, be);
      end else begin
        m_err = 1'b1;
      end
    end
    er = !m_in(ia, BASE, DEPTH);
    if (er) ed = '0;
    else begin
      w = (ia - BASE) / 4;
      ed = mm[w];
    end
    step();
    ld_valid = 1'b0;
    ld_done  = 1'b0;
  endtask

  typedef struct {
    logic v; logic [31:0] a; logic [31:0] d; logic [3:0] be;
    logic [31:0] ia; logic [31:0] exp_d; logic exp_re; logic exp_lerr;
  } vec_t;

  typedef struct { logic [31:0] a; logic exp_re; } rvec_t;

  initial begin
    vec_t        tbl[12];
    rvec_t       rt[8];
    logic [31:0] ed;
    logic        er;

    tbl[0]  = '{1'b1, 32'h0,  32'h0000_0013, 4'hF, 32'h0,         32'h0000_0013, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h4,  32'h00a0_0093, 4'hF, 32'h0,         32'h0000_0013, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,  32'h0,         4'h0, 32'h4,         32'h00a0_0093, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,  32'h0,         4'h0, 32'h6,         32'h00a0_0093, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 32'h8,  32'h1122_3344, 4'hF, 32'h0,         32'h0000_0013, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 32'h8,  32'hAABB_CCDD, 4'h5, 32'h4,         32'h00a0_0093, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,  32'h0,         4'h0, 32'h8,         32'h11BB_33DD, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,  32'h0,         4'h0, 32'h40,        32'h0,         1'b1, 1'b0};
    tbl[8]  = '{1'b1, 32'h40, 32'h0000_0055, 4'hF, 32'h3C,        32'h0,         1'b0, 1'b1};
    tbl[9]  = '{1'b0, 32'h0,  32'h0,         4'h0, 32'hFFFF_FFFC, 32'h0,         1'b1, 1'b1};
    tbl[10] = '{1'b1, 32'h8,  32'hFFFF_FFFF, 4'h0, 32'h8,         32'h11BB_33DD, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 32'h0,  32'h0,         4'h0, 32'h2,         32'h0000_0013, 1'b0, 1'b1};

    rt[0] = '{32'h0000_0FFC, 1'b1};
    rt[1] = '{32'h0000_1000, 1'b0};
    rt[2] = '{32'h0000_1003, 1'b0};
    rt[3] = '{32'h0000_101C, 1'b0};
    rt[4] = '{32'h0000_101F, 1'b0};
    rt[5] = '{32'h0000_1020, 1'b1};
    rt[6] = '{32'h0000_0000, 1'b1};
    rt[7] = '{32'hFFFF_FFFC, 1'b1};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_data", im_data, 32'h0);
    chk("rst_rerr", 32'(im_rerr), 32'h0);
    chk("rst_ready", 32'(ld_ready), 32'h0);
    chk("rst_lderr", 32'(ld_err), 32'h0);
    chk("rst_run", 32'(cpu_run), 32'h0);

    // CLEAR: ready low for DEPTH cycles, reads forced to zero
    rst = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      im_addr = $urandom_range(0, 15) * 4;
      step();
      chk("clr_ready", 32'(ld_ready), 32'(c == 16));
      chk("clr_data", im_data, 32'h0);
      chk("clr_run", 32'(cpu_run), 32'h0);
    end
    for (int i = 0; i < 16; i++) mm[i] = '0;
    m_err = 1'b0;

    // Directed LOAD table
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].be, 1'b0, tbl[i].ia, ed, er);
      chk($sformatf("tbl%0d_data", i), im_data, tbl[i].exp_d);
      chk($sformatf("tbl%0d_rerr", i), 32'(im_rerr), 32'(tbl[i].exp_re));
      chk($sformatf("tbl%0d_lderr", i), 32'(ld_err), 32'(tbl[i].exp_lerr));
      chk($sformatf("tbl%0d_ready", i), 32'(ld_ready), 32'h1);
    end

    // Done with a write in the same cycle; run rises one cycle after RUN
    cyc(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0, ed, er);
    chk("done_run0", 32'(cpu_run), 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h10, ed, er);
    chk("done_run1", 32'(cpu_run), 32'h1);
    chk("done_commit", im_data, 32'hCAFE_F00D);
    chk("run_ready", 32'(ld_ready), 32'h1);

    // Write-first collisions in RUN
    cyc(1'b1, 32'hC, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'hC, ed, er);
    chk("coll_full", im_data, 32'hDEAD_BEEF);
    cyc(1'b1, 32'hC, 32'h0000_0011, 4'h1, 1'b0, 32'hE, ed, er);
    chk("coll_lane", im_data, 32'hDEAD_BE11);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      cyc(1'($urandom_range(0, 1)), 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3)),
          $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3)), ed, er);
      chk("rnd_data", im_data, ed);
      chk("rnd_rerr", 32'(im_rerr), 32'(er));
      chk("rnd_lderr", 32'(ld_err), 32'(m_err));
      chk("rnd_run", 32'(cpu_run), 32'h1);
    end

    // Second instance: non-zero base, no clear, range edges
    chk("d2_ready", 32'(ld_ready2), 32'h1);
    for (int i = 0; i < 8; i++) begin
      im_addr2 = rt[i].a;
      step();
      chk($sformatf("d2_rerr%0d", i), 32'(im_rerr2), 32'(rt[i].exp_re));
      if (rt[i].exp_re) chk($sformatf("d2_data%0d", i), im_data2, 32'h0);
    end
    ld_valid2 = 1'b1; ld_addr2 = 32'h101C;
    step();
    ld_valid2 = 1'b0;
    chk("d2_lderr_in", 32'(ld_err2), 32'h0);
    ld_valid2 = 1'b1; ld_addr2 = 32'h0FFC;
    step();
    ld_valid2 = 1'b0;
    chk("d2_lderr_below", 32'(ld_err2), 32'h1);
    chk("d2_run", 32'(cpu_run2), 32'h0);

    // Early done during CLEAR
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      ld_done = (c == 5);
      im_addr = 32'h4;
      step();
      ld_done = 1'b0;
      chk("early_ready", 32'(ld_ready), 32'(c >= 16));
      chk("early_run", 32'(cpu_run), 32'(c >= 18));
    end

    // Reset in the middle of LOAD
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (16) step();
    ld_valid = 1'b1; ld_addr = 32'h4; ld_data = 32'h1234_5678; ld_be = 4'hF;
    step();
    ld_addr = 32'h40; im_addr = 32'h4;
    step();
    ld_valid = 1'b0; im_addr = 32'h44;
    chk("mid_pre_data", im_data, 32'h1234_5678);
    chk("mid_pre_lderr", 32'(ld_err), 32'h1);
    step();
    chk("mid_pre_rerr", 32'(im_rerr), 32'h1);
    im_addr = 32'h4;
    rst = 1'b0;
    #1;
    chk("mid_rst_data", im_data, 32'h0);
    chk("mid_rst_rerr", 32'(im_rerr), 32'h0);
    chk("mid_rst_ready", 32'(ld_ready), 32'h0);
    chk("mid_rst_lderr", 32'(ld_err), 32'h0);
    chk("mid_rst_run", 32'(cpu_run), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      step();
      chk("mid_clr_ready", 32'(ld_ready), 32'(c >= 16));
      chk("mid_clr_data", im_data, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete, required completion before 200000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/kamikaze_imem.md
Name: kamikaze_imem

Overview:
- Instruction-memory responder for the kamikaze fetch unit. It serves the `im_addr` → `im_data` read bus with a fixed 1-cycle registered latency, which is the latency fetch expects: data for the address presented in cycle N appears in cycle N+1.
- It also owns program loading: a handshaked byte-enable write port and a boot sequencer (CLEAR → LOAD → RUN).
- The sequencer gates core execution through `cpu_run_o`.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words (power of two, ≥ 4).
- BASE_ADDR, 32'h0, byte address of word 0; equals the core's CPU_START.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = go straight to LOAD.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- im_addr_i  in  32  fetch byte address; bits [1:0] ignored
- im_data_o  out  32  read data for the previous cycle's `im_addr_i`
- im_range_err_o  out  1  aligned with `im_data_o`; previous address was out of range
- ld_valid_i  in  1  loader write request
- ld_ready_o  out  1  loader write accepted when valid && ready
- ld_addr_i  in  32  loader byte address; bits [1:0] ignored
- ld_data_i  in  32  loader write data
- ld_be_i  in  4  byte enables; bit k writes byte lane k (little-endian)
- ld_done_i  in  1  single-cycle pulse: program load complete
- ld_err_o  out  1  sticky: an accepted write was out of range
- cpu_run_o  out  1  high = core may run; core holds its own reset while low

Behaviour:
- Reset values (asynchronous, rst_i low): `im_data_o`=0, `im_range_err_o`=0, `ld_ready_o`=0, `ld_err_o`=0, `cpu_run_o`=0, clear counter=0, done_pend=0.
  - State after reset = CLEAR if CLEAR_ON_RESET, else LOAD.
  - Array contents are not reset.
- Address decode:
  - idx = (addr − BASE_ADDR) >> 2.
  - In range iff addr ≥ BASE_ADDR and idx < DEPTH_WORDS (32-bit unsigned compare; no wrap into the array).
  - addr[1:0] is dropped, so the unaligned/+6 addresses fetch emits map to the containing word.
- Read port (active in every state):
  - Each cycle, `im_data_o` <= mem[idx(im_addr_i)] if in range, else 0.
  - `im_range_err_o` <= !in_range.
  - In CLEAR, `im_data_o` <= 0 regardless of address.
  - Read/write collision on the same word in the same cycle is write-first: `im_data_o` returns the old word with the enabled lanes replaced by `ld_data_i`.
- State CLEAR:
  - Writes 0 to word cnt each cycle; cnt increments.
  - When cnt == DEPTH_WORDS−1 is written, go to LOAD; DEPTH_WORDS cycles total.
  - `ld_ready_o`=0.
  - An `ld_done_i` pulse here sets done_pend.
- State LOAD:
  - `ld_ready_o`=1.
  - Accepted write updates only the enabled lanes; ld_be_i=0 is an accepted no-op.
  - An out-of-range accepted write is dropped and sets `ld_err_o`.
  - `ld_done_i` or done_pend → RUN next cycle.
  - A write accepted in the same cycle as `ld_done_i` is committed.
- State RUN:
  - `cpu_run_o`=1, registered: it rises the cycle after entering RUN.
  - `ld_ready_o` stays 1 (debug patching); `ld_done_i` is ignored.
  - RUN is left only via reset.
- Reset mid-CLEAR or mid-LOAD: abort immediately, restart the sequence from the reset state; partial contents are not guaranteed.
- `ld_ready_o` is a registered function of state only; it never depends combinationally on `ld_valid_i`.

Decomposition:
- Shared package kamikaze_pkg:
  - imem_state_t enum {IMEM_CLEAR, IMEM_LOAD, IMEM_RUN}
  - CPU_START (32'h0), shared with fetch
  - byte-lane merge function
- Sub-module kamikaze_imem_ram:
  - DEPTH_WORDS×32 array, one byte-enable write port, one synchronous read port, write-first bypass.
  - Sequencer and decode stay in the top.

Test Plan:
- CLEAR: reset with CLEAR_ON_RESET=1, DEPTH_WORDS=16 → `ld_ready_o` low for exactly 16 cycles; `im_data_o`=0 throughout; `cpu_run_o`=0.
- Load and run: write 0x00000013 @0x0, 0x00a00093 @0x4, be=4'hF, pulse `ld_done_i` → `cpu_run_o` high one cycle later. `im_addr_i`=0x4 in cycle N → `im_data_o`=0x00a00093 in N+1. `im_addr_i`=0x6 → the same word.
- Byte enables: word @0x8 = 0x11223344, then write 0xAABBCCDD with be=4'b0101 → read 0x11BB33DD.
- Collision: in RUN, write 0xDEADBEEF be=4'hF @0xC while `im_addr_i`=0xC in the same cycle → next-cycle `im_data_o`=0xDEADBEEF.
- Range: `im_addr_i`=BASE+4*DEPTH → `im_data_o`=0, `im_range_err_o`=1. Loader write to the same address → accepted, array unchanged, `ld_err_o` sticky 1 until reset.
- Early done and reset: pulse `ld_done_i` during CLEAR → RUN is entered the cycle after CLEAR ends. Drop rst_i mid-LOAD → all outputs at reset values, CLEAR restarts from cnt=0.
